// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: states, condition
// codes, datapath select values and data-processing command decode.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_EQ = 4'b0000, C_NE = 4'b0001, C_CS = 4'b0010, C_CC = 4'b0011,
    C_MI = 4'b0100, C_PL = 4'b0101, C_VS = 4'b0110, C_VC = 4'b0111,
    C_HI = 4'b1000, C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011,
    C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110, C_NV = 4'b1111
  } cond_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_RN = 2'b00;
  localparam logic [1:0] SRCA_PC = 2'b01;
  localparam logic [1:0] SRCA_BR = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Returns {supported, updates_cv, alu_control}
  function automatic logic [3:0] dp_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: dp_decode = {2'b11, ALU_ADD};
      CMD_SUB: dp_decode = {2'b11, ALU_SUB};
      CMD_CMP: dp_decode = {2'b11, ALU_SUB};
      CMD_AND: dp_decode = {2'b10, ALU_AND};
      CMD_ORR: dp_decode = {2'b10, ALU_ORR};
      default: dp_decode = {2'b00, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/cond_eval.sv
// ARM condition-field evaluator: decides whether an instruction executes
// given its 4-bit Cond field and the current NZCV flags.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);

  logic w_n, w_z, w_c, w_v, w_ge;

  assign {w_n, w_z, w_c, w_v} = i_flags;
  assign w_ge = (w_n == w_v);

  always_comb begin
    o_cond_ex = 1'b0;
    case (cond_t'(i_cond))
      C_EQ:    o_cond_ex = w_z;
      C_NE:    o_cond_ex = ~w_z;
      C_CS:    o_cond_ex = w_c;
      C_CC:    o_cond_ex = ~w_c;
      C_MI:    o_cond_ex = w_n;
      C_PL:    o_cond_ex = ~w_n;
      C_VS:    o_cond_ex = w_v;
      C_VC:    o_cond_ex = ~w_v;
      C_HI:    o_cond_ex = w_c & ~w_z;
      C_LS:    o_cond_ex = ~(w_c & ~w_z);
      C_GE:    o_cond_ex = w_ge;
      C_LT:    o_cond_ex = ~w_ge;
      C_GT:    o_cond_ex = ~w_z & w_ge;
      C_LE:    o_cond_ex = ~(~w_z & w_ge);
      C_AL:    o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer with NZCV flag register. Define MEM_WAIT_EN to
// make FETCH/MEMRD/MEMWR wait for the MemReady strobe.
module mc_control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_op,
  input  logic [5:0] i_funct,
  input  logic [3:0] i_rd,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic       o_ir_write,
  output logic       o_adr_src,
  output logic [1:0] o_reg_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic [1:0] o_imm_src,
  output logic [1:0] o_alu_control,
  output logic [3:0] o_flags
);

  state_t     r_state, w_next;
  logic [3:0] r_flags;
  logic       r_cond_q;
  logic       w_cond_ex;
  logic       w_ready;
  logic [3:0] w_dp;
  logic       w_is_cmp;
  logic       w_flag_we;
  logic       w_pc_write, w_mem_write, w_reg_write, w_ir_write;

`ifdef MEM_WAIT_EN
  assign w_ready = i_mem_ready;
`else
  logic w_unused;
  assign w_unused = i_mem_ready;
  assign w_ready  = 1'b1;
`endif

  cond_eval u_cond_eval (
    .i_cond    (i_cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  assign w_dp     = dp_decode(i_funct[4:1]);
  assign w_is_cmp = (i_funct[4:1] == CMD_CMP);
  assign w_flag_we = ((r_state == S_EXECR) || (r_state == S_EXECI)) && r_cond_q &&
                     w_dp[3] && (i_funct[0] || w_is_cmp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_flags  <= 4'b0000;
      r_cond_q <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cond_q <= w_cond_ex;
      if (w_flag_we) begin
        r_flags[3:2] <= i_alu_flags[3:2];
        // Logical ops leave carry/overflow untouched
        if (w_dp[2]) r_flags[1:0] <= i_alu_flags[1:0];
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_pc_write    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_ir_write    = 1'b0;
    o_adr_src     = 1'b0;
    o_alu_src_a   = SRCA_RN;
    o_alu_src_b   = SRCB_REG;
    o_result_src  = RES_ALUOUT;
    o_alu_control = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_pc_write   = w_ready;
        w_ir_write   = w_ready;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALU;
        if (w_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALU;
        case (i_op)
          OP_MEM:  w_next = S_MEMADR;
          OP_DP:   w_next = i_funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        o_alu_src_b   = SRCB_IMM;
        o_alu_control = i_funct[3] ? ALU_ADD : ALU_SUB;
        w_next        = i_funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        o_adr_src = 1'b1;
        if (w_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_result_src = RES_DATA;
        w_reg_write  = r_cond_q;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        o_adr_src   = 1'b1;
        w_mem_write = r_cond_q & w_ready;
        if (w_ready) w_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        o_alu_src_b   = (r_state == S_EXECI) ? SRCB_IMM : SRCB_REG;
        o_alu_control = w_dp[1:0];
        w_next        = w_is_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        // A write to R15 redirects the PC instead of the register file
        w_pc_write  = r_cond_q & w_dp[3] & (i_rd == 4'd15);
        w_reg_write = r_cond_q & w_dp[3] & (i_rd != 4'd15);
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a  = SRCA_BR;
        o_alu_src_b  = SRCB_IMM;
        o_result_src = RES_ALU;
        w_pc_write   = r_cond_q;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign o_pc_write  = w_pc_write  & rst_n;
  assign o_mem_write = w_mem_write & rst_n;
  assign o_reg_write = w_reg_write & rst_n;
  assign o_ir_write  = w_ir_write  & rst_n;
  assign o_reg_src   = {(i_op == OP_MEM) & ~i_funct[0], (i_op == OP_BR)};
  assign o_imm_src   = i_op;
  assign o_flags     = r_flags;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus queues the expected control
// word for every cycle, a negedge monitor pops and compares.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       pcw, memw, regw, irw, adr;
    logic [1:0] rs, sa, sb, res, imm, alu;
    logic [3:0] f;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cnd, aluf;
  logic       mem_ready;
  logic       pc_write, mem_write, reg_write, ir_write, adr_src;
  logic [1:0] reg_src, alu_src_a, alu_src_b, result_src, imm_src, alu_control;
  logic [3:0] flags;

  ctl_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_op          (op),
    .i_funct       (funct),
    .i_rd          (rd),
    .i_cond        (cnd),
    .i_alu_flags   (aluf),
    .i_mem_ready   (mem_ready),
    .o_pc_write    (pc_write),
    .o_mem_write   (mem_write),
    .o_reg_write   (reg_write),
    .o_ir_write    (ir_write),
    .o_adr_src     (adr_src),
    .o_reg_src     (reg_src),
    .o_alu_src_a   (alu_src_a),
    .o_alu_src_b   (alu_src_b),
    .o_result_src  (result_src),
    .o_imm_src     (imm_src),
    .o_alu_control (alu_control),
    .o_flags       (flags)
  );

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e;
      ctl_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {pc_write, mem_write, reg_write, ir_write, adr_src, reg_src, alu_src_a,
            alu_src_b, result_src, imm_src, alu_control, flags};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: actual=%b required=%b (pcw,memw,regw,irw,adr,rs,sa,sb,res,imm,alu,nzcv)",
                 nm, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t v(input logic pcw, memw, regw, irw, adr,
                             input logic [1:0] rs, sa, sb, res, imm, alu,
                             input logic [3:0] f);
    return ctl_t'({pcw, memw, regw, irw, adr, rs, sa, sb, res, imm, alu, f});
  endfunction

  task automatic step(input string nm, input ctl_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [1:0] o, input logic [5:0] fn,
                       input logic [3:0] r, input logic [3:0] c, input logic [3:0] af);
    op = o; funct = fn; rd = r; cnd = c; aluf = af;
  endtask

  task automatic fe(input string nm, input logic [1:0] rs, imm, input logic [3:0] f);
    step(nm, v(1, 0, 0, 1, 0, rs, 2'b01, 2'b10, 2'b10, imm, 2'b00, f));
  endtask

  task automatic de(input string nm, input logic [1:0] rs, imm, input logic [3:0] f);
    step(nm, v(0, 0, 0, 0, 0, rs, 2'b01, 2'b10, 2'b10, imm, 2'b00, f));
  endtask

  task automatic br(input string nm, input logic [3:0] c, input logic taken);
    instr(2'b10, 6'b000000, 4'd0, c, 4'b0000);
    fe(nm, 2'b01, 2'b10, 4'h9);
    de(nm, 2'b01, 2'b10, 4'h9);
    step(nm, v(taken, 0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 4'h9));
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    instr(2'b00, 6'b001000, 4'd1, 4'b1110, 4'b1111);
    @(posedge clk);
    #1;
    repeat (3) step("reset", v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h0));
    rst_n = 1'b1;

    // ADD R1,R2,R3 without S: live flags 1111 must not load
    fe("add.fetch", 2'b00, 2'b00, 4'h0);
    de("add.decode", 2'b00, 2'b00, 4'h0);
    step("add.execr", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0));
    step("add.aluwb", v(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0));

    instr(2'b00, 6'b000101, 4'd1, 4'b1110, 4'b0010);
    fe("subs.fetch", 2'b00, 2'b00, 4'h0);
    de("subs.decode", 2'b00, 2'b00, 4'h0);
    step("subs.execr", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 4'h0));
    step("subs.aluwb", v(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h2));

    instr(2'b00, 6'b010101, 4'd0, 4'b1110, 4'b0100);
    fe("cmp.fetch", 2'b00, 2'b00, 4'h2);
    de("cmp.decode", 2'b00, 2'b00, 4'h2);
    step("cmp.execr", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 4'h2));

    instr(2'b10, 6'b000000, 4'd0, 4'b0000, 4'b0000);
    fe("beq.fetch", 2'b01, 2'b10, 4'h4);
    de("beq.decode", 2'b01, 2'b10, 4'h4);
    step("beq.branch", v(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 4'h4));
    cnd = 4'b0001;
    fe("bne.fetch", 2'b01, 2'b10, 4'h4);
    de("bne.decode", 2'b01, 2'b10, 4'h4);
    step("bne.branch", v(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 4'h4));

    instr(2'b00, 6'b001001, 4'd3, 4'b0001, 4'b1111);
    fe("addsne.fetch", 2'b00, 2'b00, 4'h4);
    de("addsne.decode", 2'b00, 2'b00, 4'h4);
    step("addsne.execr", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h4));
    step("addsne.aluwb", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h4));

    instr(2'b00, 6'b001001, 4'd3, 4'b1110, 4'b0001);
    fe("adds.fetch", 2'b00, 2'b00, 4'h4);
    de("adds.decode", 2'b00, 2'b00, 4'h4);
    step("adds.execr", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h4));
    step("adds.aluwb", v(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h1));

    instr(2'b00, 6'b000001, 4'd4, 4'b1110, 4'b1011);
    fe("ands.fetch", 2'b00, 2'b00, 4'h1);
    de("ands.decode", 2'b00, 2'b00, 4'h1);
    step("ands.execr", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 4'h1));
    step("ands.aluwb", v(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h9));

    instr(2'b00, 6'b111000, 4'd15, 4'b1110, 4'b0000);
    fe("orrpc.fetch", 2'b00, 2'b00, 4'h9);
    de("orrpc.decode", 2'b00, 2'b00, 4'h9);
    step("orrpc.execi", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 4'h9));
    step("orrpc.aluwb", v(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h9));

    br("bge", 4'b1010, 1'b1);
    br("blt", 4'b1011, 1'b0);
    br("bnv", 4'b1111, 1'b0);

    instr(2'b00, 6'b000011, 4'd5, 4'b1110, 4'b0000);
    fe("eors.fetch", 2'b00, 2'b00, 4'h9);
    de("eors.decode", 2'b00, 2'b00, 4'h9);
    step("eors.execr", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h9));
    step("eors.aluwb", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h9));

    instr(2'b01, 6'b011001, 4'd2, 4'b1110, 4'b0000);
`ifdef MEM_WAIT_EN
    fe("ldr.fetch", 2'b00, 2'b01, 4'h9);
    de("ldr.decode", 2'b00, 2'b01, 4'h9);
    step("ldr.memadr", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 4'h9));
    mem_ready = 1'b0;
    repeat (3) step("ldr.memrd_wait", v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'h9));
    mem_ready = 1'b1;
    step("ldr.memrd", v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'h9));
`else
    mem_ready = 1'b0;
    fe("ldr.fetch", 2'b00, 2'b01, 4'h9);
    de("ldr.decode", 2'b00, 2'b01, 4'h9);
    step("ldr.memadr", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 4'h9));
    step("ldr.memrd", v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'h9));
`endif
    step("ldr.memwb", v(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 4'h9));
    mem_ready = 1'b1;

    instr(2'b01, 6'b010000, 4'd6, 4'b1110, 4'b0000);
    fe("str.fetch", 2'b10, 2'b01, 4'h9);
    de("str.decode", 2'b10, 2'b01, 4'h9);
    step("str.memadr", v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 4'h9));
    step("str.memwr", v(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'h9));
    cnd = 4'b0000;
    fe("streq.fetch", 2'b10, 2'b01, 4'h9);
    de("streq.decode", 2'b10, 2'b01, 4'h9);
    step("streq.memadr", v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 4'h9));
    step("streq.memwr", v(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'h9));

    instr(2'b11, 6'b000000, 4'd0, 4'b1110, 4'b0000);
    fe("undef.fetch", 2'b00, 2'b11, 4'h9);
    de("undef.decode", 2'b00, 2'b11, 4'h9);

    // Reset pulled in ALUWB: no writes that cycle, then clean FETCH
    instr(2'b00, 6'b001000, 4'd1, 4'b1110, 4'b1111);
    fe("rstwb.fetch", 2'b00, 2'b00, 4'h9);
    de("rstwb.decode", 2'b00, 2'b00, 4'h9);
    step("rstwb.execr", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h9));
    rst_n = 1'b0;
    step("rstwb.aluwb", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h9));
    rst_n = 1'b1;
    fe("rstwb.refetch", 2'b00, 2'b00, 4'h0);
    de("rstwb.decode2", 2'b00, 2'b00, 4'h0);
    step("rstwb.execr2", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0));
    step("rstwb.aluwb2", v(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0));

`ifdef MEM_WAIT_EN
    instr(2'b01, 6'b011001, 4'd2, 4'b1110, 4'b0000);
    fe("rstrd.fetch", 2'b00, 2'b01, 4'h0);
    de("rstrd.decode", 2'b00, 2'b01, 4'h0);
    step("rstrd.memadr", v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 4'h0));
    mem_ready = 1'b0;
    rst_n = 1'b0;
    step("rstrd.memrd", v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'h0));
    rst_n = 1'b1;
    mem_ready = 1'b1;
    fe("rstrd.refetch", 2'b00, 2'b01, 4'h0);
`endif

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
